// File: rtl/booth_host_if.sv
// System-side operand/result handshake bundle for booth_host.
// The slave modport is the sequencer; the master modport is the producer/consumer.
interface booth_host_if;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_product;
    logic        res_timeout;

    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_product, res_timeout
    );

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_product, res_timeout
    );
endinterface

// File: rtl/booth_host.sv
// Initiator-side sequencer for the 8-bit Booth multiplier: loads M then Q,
// waits for done with a timeout, reads the product high byte then low byte.
module booth_host #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    booth_host_if.slave  host,
    output logic         mul_enable_o,
    output logic [7:0]   mul_inbus_o,
    input  logic         mul_done_i,
    input  logic [7:0]   mul_outbus_i,
    output logic         busy_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_M, WAIT_DONE, READ_LO, RESP} state_t;

    state_t        state_q, state_d;
    logic          live_q;
    logic [7:0]    a_q, b_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   prod_q;
    logic          tmo_q;
    logic          accept;
    logic          timeout_hit;

    // live_q keeps op_ready low while reset is held and for no longer.
    assign accept      = (state_q == IDLE) && live_q && host.op_valid;
    assign timeout_hit = !mul_done_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LOAD_M;
            LOAD_M:    state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (mul_done_i)       state_d = READ_LO;
                else if (timeout_hit) state_d = RESP;
            end
            READ_LO:   state_d = RESP;
            RESP:      if (host.res_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        host.op_ready   = live_q && (state_q == IDLE);
        host.res_valid  = (state_q == RESP);
        mul_enable_o    = (state_q == LOAD_M);
        busy_o          = (state_q != IDLE);
        mul_inbus_o     = 8'h00;
        case (state_q)
            LOAD_M:            mul_inbus_o = a_q;
            WAIT_DONE, READ_LO: mul_inbus_o = b_q;
            default:           mul_inbus_o = 8'h00;
        endcase
    end

    assign host.res_product = prod_q;
    assign host.res_timeout = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            cnt_q  <= '0;
            prod_q <= 16'h0000;
            tmo_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                IDLE: if (accept) begin
                    a_q    <= host.op_a;
                    b_q    <= host.op_b;
                    prod_q <= 16'h0000;
                    tmo_q  <= 1'b0;
                end
                LOAD_M: cnt_q <= '0;
                WAIT_DONE: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
                    if (mul_done_i) begin
                        prod_q[15:8] <= mul_outbus_i;
                    end else if (timeout_hit) begin
                        prod_q <= 16'h0000;
                        tmo_q  <= 1'b1;
                    end
                end
                READ_LO: prod_q[7:0] <= mul_outbus_i;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/booth_host.md
# booth_host

Initiator-side sequencer for the 8-bit Booth multiplier bus. It accepts a pair of signed 8-bit operands over a valid/ready handshake and drives the multiplier's load protocol: `enable` with M on `inbus`, then Q on `inbus` until `done`. It then captures the 16-bit product from `outbus` over two cycles and returns it on a valid/ready result port. It sits between a system-side producer/consumer and the `booth` multiplier and shares that multiplier's clock and reset.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles spent in WAIT_DONE before the transaction is aborted. Must be ≥ 1.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `op_valid` input 1: operand pair valid.
- `op_ready` output 1: block can accept operands.
- `op_a` input 8: multiplicand M, signed two's complement.
- `op_b` input 8: multiplier Q, signed two's complement.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts result.
- `res_product` output 16: signed product `op_a*op_b`.
- `res_timeout` output 1: qualifies `res_valid`; set when the multiplier never asserted `done`.
- `mul_enable` output 1: drives multiplier `enable`.
- `mul_inbus` output 8: drives multiplier `inbus`.
- `mul_done` input 1: multiplier `done`.
- `mul_outbus` input 8: multiplier `outbus`.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD_M, WAIT_DONE, READ_LO, RESP.
- **IDLE**
  - `op_ready`=1.
  - On `op_valid & op_ready`: register `op_a` and `op_b`, then go to LOAD_M.
- **LOAD_M** (exactly 1 cycle)
  - `mul_enable`=1, `mul_inbus`=A.
  - Next state: WAIT_DONE.
  - Clear the timeout counter.
- **WAIT_DONE**
  - `mul_enable`=0, `mul_inbus`=B, held stable for the whole state.
  - Counter increments every cycle.
  - If `mul_done` is sampled 1: capture `mul_outbus` into `product[15:8]`, go to READ_LO.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES-1`: set the timeout flag, set `product`=0, go to RESP.
  - If `mul_done` and the timeout boundary occur in the same cycle, `done` wins; no timeout is flagged.
- **READ_LO** (exactly 1 cycle)
  - Capture `mul_outbus` into `product[7:0]` unconditionally.
  - `mul_inbus`=B.
  - Next state: RESP.
- **RESP**
  - `res_valid`=1; `res_product` and `res_timeout` are held stable.
  - On `res_ready`: go to IDLE.
  - `op_ready` stays 0, so a new operand is never accepted in the same cycle a result retires.
- `mul_done` is ignored in every state other than WAIT_DONE.
- Arithmetic:
  - No arithmetic is performed by this block; the bytes are concatenated verbatim.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- Reset mid-operation:
  - State returns to IDLE immediately (asynchronously).
  - `mul_enable` drops with reset.
  - Any in-flight result is discarded; no `res_valid` is produced for it.

## Timing
- Reset values:
  - While `rst_n`=0, every output is 0, including `op_ready`.
  - Registered results reset to 0: `res_product`=0, `res_timeout`=0.
  - `op_ready`=1 in the first cycle after `rst_n` deasserts.
- All outputs decode directly from registered state/data; there are no combinational paths from inputs to outputs.
- Cycle numbering, with the accept edge as cycle 0:
  - Cycle 1: LOAD_M; `mul_enable`=1.
  - Cycle 2 onward: WAIT_DONE.
  - If `mul_done` is sampled at cycle D: READ_LO at D+1, `res_valid` at D+2.
- Minimum accept-to-result latency is 4 cycles, when `done` arrives at cycle 2.
- `mul_enable` is high for exactly one cycle per transaction.
- `mul_inbus` changes from A to B on the same edge that `mul_enable` falls.
- Timeout: `res_valid` is asserted at cycle `2+TIMEOUT_CYCLES` with `res_timeout`=1.
- Back-to-back throughput: at most one transaction per (D+3) cycles; IDLE always lasts ≥ 1 cycle.

## Test plan
- **Basic product:** reset, then apply `op_a`=-3 (0xFD), `op_b`=5 against `booth`. Required: one `mul_enable` pulse with `inbus`=0xFD, `inbus`=0x05 until `done`, `res_product`=0xFFF1, `res_timeout`=0.
- **Extremes:** apply 127 × -128 and -128 × -128. Required: 0xC080 and 0x4000, each compared against a behavioural signed multiply.
- **Backpressure:** hold `res_ready`=0 for 10 cycles after `res_valid`. Required: product and flags stable, `op_ready`=0 throughout; IDLE is reached one cycle after `res_ready`.
- **Timeout:** use a stub multiplier that never asserts `done`, with `TIMEOUT_CYCLES`=8. Required: `res_valid` at cycle 10, `res_timeout`=1, `res_product`=0.
- **Done at timeout boundary:** stub asserts `done` at cycle `2+TIMEOUT_CYCLES-1`. Required: normal result, `res_timeout`=0.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT_DONE. Required: all outputs 0 immediately, no `res_valid` for the aborted operation; the next transaction returns the correct product.
